// File: rtl/decd_pkg.sv
// ---------------------------------------------------------------------------
// decd_pkg
// Shared types and helpers for the decd_onehot_seq decoder slice.
//   decd_state_t : controller states (IDLE, DIRECT, SCAN)
//   MODE_DIRECT  : value of the mode port selecting handshaked decode
//   MODE_SCAN    : value of the mode port selecting autonomous scanning
//   onehot_of()  : binary-to-one-hot helper, sized for the widest legal
//                  select (6 bits -> 64 outputs); callers truncate with a cast
// ---------------------------------------------------------------------------
package decd_pkg;

    localparam int MAX_SEL_W = 6;
    localparam int MAX_OUT_W = 2 ** MAX_SEL_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } decd_state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Full-width decode; the caller keeps only the low 2**SEL_W bits.
    function automatic logic [MAX_OUT_W-1:0] onehot_of(input logic [MAX_SEL_W-1:0] sel);
        return MAX_OUT_W'(1) << sel;
    endfunction

endpackage

// File: rtl/decd_dwell_cnt.sv
// ---------------------------------------------------------------------------
// decd_dwell_cnt
// Dwell counter that paces the scan walk. Counts 0..HOLD_CYC-1 and wraps;
// tc_o is high while the count sits at HOLD_CYC-1, so an enabled edge with
// tc_o high is the edge on which the scan position advances.
// Ports:
//   clk_i  : clock, rising edge
//   clr_i  : synchronous clear to 0 (also carries the block reset)
//   en_i   : count enable; when low the count is frozen
//   tc_o   : terminal count flag (count == HOLD_CYC-1)
// ---------------------------------------------------------------------------
module decd_dwell_cnt #(
    parameter int HOLD_CYC = 4
) (
    input  logic clk_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int CNT_W = $clog2(HOLD_CYC) + 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Wrap to zero on terminal count so each position lasts exactly HOLD_CYC edges.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            if (tc_o) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Count register.
    always_ff @(posedge clk_i) begin
        cnt_q <= cnt_d;
    end

    assign tc_o = (cnt_q == CNT_W'(HOLD_CYC - 1));

endmodule

// File: rtl/decd_onehot_seq.sv
// ---------------------------------------------------------------------------
// decd_onehot_seq
// Registered binary-to-one-hot decoder with two modes:
//   direct : decodes a valid/ready handshaked select, one transfer per cycle
//   scan   : walks the one-hot output by itself, HOLD_CYC cycles per position
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   en         : enable; low blanks the outputs and freezes all state
//   mode       : 0 = direct decode, 1 = auto-scan
//   in_valid   : in_sel valid (direct mode)
//   in_ready   : block accepts in_sel this cycle
//   in_sel     : binary select
//   out_valid  : out_onehot/out_idx carry a valid code
//   out_ready  : consumer accepts the output (direct mode)
//   out_onehot : registered one-hot code (all-zero when blanked/reset)
//   out_idx    : binary index of the code on out_onehot
// Build option:
//   DECD_ACTIVE_LOW_EN : when defined, out_onehot is inverted (one-cold,
//                        idle value all-ones) for common-anode displays.
// ---------------------------------------------------------------------------
module decd_onehot_seq
    import decd_pkg::*;
#(
    parameter  int SEL_W    = 3,
    parameter  int HOLD_CYC = 4,
    localparam int OUT_W    = 2 ** SEL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SEL_W-1:0] in_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_onehot,
    output logic [SEL_W-1:0] out_idx
);

    decd_state_t      state_q,  state_d;
    logic [OUT_W-1:0] onehot_q, onehot_d;
    logic [SEL_W-1:0] idx_q,    idx_d;
    logic             valid_q,  valid_d;

    logic             dwellClr;
    logic             dwellEn;
    logic             dwellTc;
    logic [OUT_W-1:0] decoded;
    logic [OUT_W-1:0] onehotGated;

    assign decoded = OUT_W'(onehot_of(MAX_SEL_W'(in_sel)));

    // Dwell count only runs while actively scanning; it is held at zero in
    // every other state so that entering SCAN always starts a fresh dwell.
    assign dwellClr = rst || (state_q != SCAN);
    assign dwellEn  = en && (state_q == SCAN) && (mode == MODE_SCAN);

    decd_dwell_cnt #(
        .HOLD_CYC (HOLD_CYC)
    ) u_dwell (
        .clk_i (clk),
        .clr_i (dwellClr),
        .en_i  (dwellEn),
        .tc_o  (dwellTc)
    );

    // Ready is purely combinational so back-to-back transfers sustain one per
    // cycle; it is forced low during reset and outside DIRECT.
    assign in_ready = !rst && en && (state_q == DIRECT) && (!valid_q || out_ready);

    // Next-state logic. Nothing moves while en is low, which is what lets a
    // blanked scan resume at the same position and dwell count.
    always_comb begin
        state_d  = state_q;
        onehot_d = onehot_q;
        idx_d    = idx_q;
        valid_d  = valid_q;
        if (en) begin
            unique case (state_q)
                IDLE: begin
                    if (mode == MODE_SCAN) begin
                        state_d  = SCAN;
                        idx_d    = '0;
                        onehot_d = OUT_W'(1);
                        valid_d  = 1'b1;
                    end else begin
                        state_d = DIRECT;
                    end
                end
                DIRECT: begin
                    if (mode == MODE_SCAN) begin
                        // Any pending direct output is dropped in favour of scan entry.
                        state_d  = SCAN;
                        idx_d    = '0;
                        onehot_d = OUT_W'(1);
                        valid_d  = 1'b1;
                    end else if (in_valid && in_ready) begin
                        onehot_d = decoded;
                        idx_d    = in_sel;
                        valid_d  = 1'b1;
                    end else if (out_ready) begin
                        valid_d = 1'b0;
                    end
                end
                SCAN: begin
                    if (mode == MODE_DIRECT) begin
                        state_d  = DIRECT;
                        onehot_d = '0;
                        valid_d  = 1'b0;
                    end else if (dwellTc) begin
                        idx_d    = idx_q + SEL_W'(1);
                        onehot_d = {onehot_q[OUT_W-2:0], onehot_q[OUT_W-1]};
                    end
                end
                default: begin
                    state_d  = IDLE;
                    onehot_d = '0;
                    idx_d    = '0;
                    valid_d  = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            onehot_q <= '0;
            idx_q    <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            onehot_q <= onehot_d;
            idx_q    <= idx_d;
            valid_q  <= valid_d;
        end
    end

    // Blanking is combinational so it takes effect in the same cycle as en.
    assign onehotGated = en ? onehot_q : '0;
    assign out_valid   = en && valid_q;
    assign out_idx     = idx_q;

`ifdef DECD_ACTIVE_LOW_EN
    assign out_onehot = ~onehotGated;
`else
    assign out_onehot = onehotGated;
`endif

endmodule

// File: tb/tb_decd_onehot_seq.sv
// ---------------------------------------------------------------------------
// tb_decd_onehot_seq
// Self-checking bench for decd_onehot_seq (SEL_W=3, HOLD_CYC=4). A small
// behavioural model predicts each edge; predictions are queued when the
// stimulus is driven and compared after the edge.
// Honours DECD_ACTIVE_LOW_EN for the expected out_onehot polarity.
// ---------------------------------------------------------------------------
module tb_decd_onehot_seq;

    localparam int SEL_W    = 3;
    localparam int HOLD_CYC = 4;
    localparam int OUT_W    = 2 ** SEL_W;

    localparam int M_IDLE   = 0;
    localparam int M_DIRECT = 1;
    localparam int M_SCAN   = 2;

    logic             clk;
    logic             rst;
    logic             en;
    logic             mode;
    logic             in_valid;
    logic             in_ready;
    logic [SEL_W-1:0] in_sel;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_onehot;
    logic [SEL_W-1:0] out_idx;

    typedef struct {
        logic [OUT_W-1:0] onehot;
        logic [SEL_W-1:0] idx;
        logic             valid;
    } exp_t;

    exp_t sb[$];

    int               nChecks = 0;
    int               nPass   = 0;

    int               mState;
    logic [OUT_W-1:0] mOneHot;
    logic [SEL_W-1:0] mIdx;
    logic             mValid;
    int               mDwell;

    decd_onehot_seq #(
        .SEL_W    (SEL_W),
        .HOLD_CYC (HOLD_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .mode       (mode),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sel     (in_sel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_onehot (out_onehot),
        .out_idx    (out_idx)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Port-level view of an internal code: blanked by en, inverted when one-cold.
    function automatic logic [OUT_W-1:0] portOneHot(input logic e, input logic [OUT_W-1:0] raw);
        logic [OUT_W-1:0] v;
        v = e ? raw : '0;
`ifdef DECD_ACTIVE_LOW_EN
        v = ~v;
`endif
        return v;
    endfunction

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        nChecks++;
        if (observed !== expected) begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, observed, expected, $time);
        end else begin
            nPass++;
        end
    endtask

    // Drives one cycle of inputs, checks in_ready, advances the model,
    // queues the prediction and compares it after the clock edge.
    task automatic applyStimulus(input logic r, input logic e, input logic m, input logic iv,
                                 input logic [SEL_W-1:0] s, input logic ordy);
        logic expReady;
        exp_t item;
        exp_t got;
        rst       = r;
        en        = e;
        mode      = m;
        in_valid  = iv;
        in_sel    = s;
        out_ready = ordy;
        #1;
        expReady = !r && e && (mState == M_DIRECT) && (!mValid || ordy);
        checkOutput("in_ready", 64'(in_ready), 64'(expReady));

        if (r) begin
            mState  = M_IDLE;
            mOneHot = '0;
            mIdx    = '0;
            mValid  = 1'b0;
            mDwell  = 0;
        end else if (e) begin
            if (mState == M_IDLE) begin
                if (m) begin
                    mState = M_SCAN; mIdx = '0; mOneHot = OUT_W'(1); mValid = 1'b1; mDwell = 0;
                end else begin
                    mState = M_DIRECT;
                end
            end else if (mState == M_DIRECT) begin
                if (m) begin
                    mState = M_SCAN; mIdx = '0; mOneHot = OUT_W'(1); mValid = 1'b1; mDwell = 0;
                end else if (iv && expReady) begin
                    mOneHot = '0;
                    mOneHot[s] = 1'b1;
                    mIdx   = s;
                    mValid = 1'b1;
                end else if (ordy) begin
                    mValid = 1'b0;
                end
            end else begin
                if (!m) begin
                    mState = M_DIRECT; mValid = 1'b0; mOneHot = '0; mDwell = 0;
                end else if (mDwell == HOLD_CYC - 1) begin
                    mDwell  = 0;
                    mIdx    = mIdx + 1'b1;
                    mOneHot = '0;
                    mOneHot[mIdx] = 1'b1;
                end else begin
                    mDwell++;
                end
            end
        end

        item.onehot = portOneHot(e, mOneHot);
        item.idx    = mIdx;
        item.valid  = e && mValid;
        sb.push_back(item);

        @(posedge clk);
        #1;
        got = sb.pop_front();
        checkOutput("out_onehot", 64'(out_onehot), 64'(got.onehot));
        checkOutput("out_idx",    64'(out_idx),    64'(got.idx));
        checkOutput("out_valid",  64'(out_valid),  64'(got.valid));
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mode = 1'b0; in_valid = 1'b0; in_sel = '0; out_ready = 1'b0;
        mState = M_IDLE; mOneHot = '0; mIdx = '0; mValid = 1'b0; mDwell = 0;
        @(posedge clk);
        #1;

        // Reset: all outputs cleared, in_ready low while rst is high.
        applyStimulus(1, 1, 0, 1, 3'd5, 1);
        applyStimulus(1, 0, 0, 0, 3'd0, 0);
        checkOutput("rst_onehot", 64'(out_onehot), 64'(portOneHot(1'b1, 8'h00)));

        // Direct decode of 5: first edge leaves IDLE, second edge transfers.
        applyStimulus(0, 1, 0, 1, 3'd5, 1);
        applyStimulus(0, 1, 0, 1, 3'd5, 1);
        checkOutput("dir5_onehot", 64'(out_onehot), 64'(portOneHot(1'b1, 8'b0010_0000)));
        checkOutput("dir5_idx", 64'(out_idx), 64'd5);

        // Backpressure: transfer 2, then hold for 5 cycles with out_ready low.
        applyStimulus(0, 1, 0, 1, 3'd2, 1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 1, 0, 1, 3'd6, 0);
        end
        checkOutput("bp_hold", 64'(out_onehot), 64'(portOneHot(1'b1, 8'b0000_0100)));
        applyStimulus(0, 1, 0, 1, 3'd7, 1);
        checkOutput("dir7_onehot", 64'(out_onehot), 64'(portOneHot(1'b1, 8'b1000_0000)));
        // Drain: valid drops, code stays.
        applyStimulus(0, 1, 0, 0, 3'd0, 1);

        // Random handshake traffic, including blanked cycles.
        for (int i = 0; i < 24; i++) begin
            applyStimulus(0, ($urandom_range(7, 0) != 0), 0, 1'($urandom_range(1, 0)),
                          3'($urandom_range(7, 0)), 1'($urandom_range(1, 0)));
        end

        // Scan: full wrap and beyond, with ignored inputs toggling randomly.
        for (int i = 0; i < 40; i++) begin
            applyStimulus(0, 1, 1, 1'($urandom_range(1, 0)), 3'($urandom_range(7, 0)),
                          1'($urandom_range(1, 0)));
        end

        // Walk to idx 3, dwell 1, then blank for 3 cycles and resume.
        for (int i = 0; i < 64 && !(mIdx == 3'd3 && mDwell == 1); i++) begin
            applyStimulus(0, 1, 1, 0, 3'd0, 0);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 1, 1, 3'd1, 1);
        end
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 1, 1, 0, 3'd0, 0);
        end

        // Mode switch to direct at idx 6: output clears, ready returns.
        for (int i = 0; i < 64 && mIdx != 3'd6; i++) begin
            applyStimulus(0, 1, 1, 0, 3'd0, 0);
        end
        applyStimulus(0, 1, 0, 0, 3'd0, 0);
        applyStimulus(0, 1, 0, 1, 3'd3, 0);
        applyStimulus(0, 1, 0, 0, 3'd0, 0);

        // Back to scan, then reset in the middle of a dwell.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 1, 1, 0, 3'd0, 0);
        end
        applyStimulus(1, 1, 1, 1, 3'd4, 1);
        checkOutput("rst_mid_scan", 64'(out_onehot), 64'(portOneHot(1'b1, 8'h00)));

        // Leave IDLE into direct and decode 0.
        applyStimulus(0, 1, 0, 1, 3'd0, 1);
        applyStimulus(0, 1, 0, 1, 3'd0, 1);
        checkOutput("dir0_onehot", 64'(out_onehot), 64'(portOneHot(1'b1, 8'b0000_0001)));
        applyStimulus(0, 1, 0, 0, 3'd0, 1);

        $display("[TB] %0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
